data_memory: RTL
================

Name: data_memory

Overview:
- Byte-addressable data memory for the single-cycle RISC-V core, directly downstream of the controller.
- Consumes the memory write-enable and load/store width (funct3) decoded for each instruction, and feeds load data to the register-file write-data mux.
- Adds a post-reset clearing sweep, alignment and range checking, and a sticky fault capture register.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words (power of 2, >=2)
ADDR_W, $clog2(DEPTH_WORDS), word-index width (derived, localparam)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  synchronous, active-low reset
i_memWriteEn  input  1  store this cycle (from controller)
i_memReadEn  input  1  load this cycle (register write-data selects memory)
i_funct3  input  3  access width/sign (instruction funct3)
i_address  input  32  byte address (ALU result)
i_writeData  input  32  store data (register file read port 2)
o_readData  output  32  extended load data, combinational
o_ready  output  1  high once clearing sweep complete
o_misaligned  output  1  combinational: current access misaligned/illegal/out of range
o_faultSticky  output  1  registered: first fault seen since reset
o_faultAddress  output  32  registered: i_address of first fault

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low: i_rst_n low at a rising edge of i_clk resets the block.
- Reset values: state=CLEAR, clearIdx=0, o_faultSticky=0, o_faultAddress=0, o_ready=0. Memory contents are not reset directly; the sweep clears them.
- FSM CLEAR:
  - Each cycle writes 0 to mem[clearIdx], then clearIdx++.
  - When clearIdx==DEPTH_WORDS-1 is written, next state is READY.
  - The sweep takes exactly DEPTH_WORDS cycles after reset deasserts; o_ready rises on the following cycle.
- In CLEAR:
  - Store/load requests are ignored.
  - o_readData=0, o_misaligned=0, no fault capture.
- Reset mid-sweep restarts the sweep from index 0.
- FSM READY: terminal until reset.
- Width decode (funct3):
  - Stores: 000 SB, 001 SH, 010 SW.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Any other code for an active direction is illegal.
- Word index = i_address[ADDR_W+1:2]. Out of range when i_address[31:ADDR_W+2] != 0.
- Misaligned when H/HU and addr[0]=1, or W and addr[1:0]!=0.
- o_misaligned = READY & (rd|wr) & (illegal | misaligned | out of range).
- Store (READY, i_memWriteEn, no fault):
  - Written at the rising edge.
  - SB writes byte lane addr[1:0] from i_writeData[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} from i_writeData[15:0].
  - SW writes the full word.
  - All other lanes are unchanged.
- Faulted store performs no write.
- Load: combinational from current contents.
  - Byte/half selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
  - Faulted or inactive load gives o_readData=0.
- Simultaneous read and write enable: the write occurs at the edge; o_readData in that cycle shows pre-write contents (no bypass).
- Fault capture: at an edge with o_misaligned=1 and o_faultSticky=0, set o_faultSticky=1 and latch i_address. Subsequent faults do not overwrite it; only reset clears it.
- Latency: loads have 0 cycles (combinational); stores are visible to loads from the next cycle.

Decomposition:
- Package pa_riscv:
  - Add enum of funct3 memory widths (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU).
  - Add FSM state enum (CLEAR, READY).
- Sub-module load_extend (combinational): inputs word, addr[1:0], funct3; outputs extended 32-bit data. Instantiated once.

Test Plan:
- Clear sweep:
  - Stimulus: hold i_rst_n=0 for 2 cycles, release, DEPTH_WORDS=256.
  - Response: o_ready=0 for exactly 256 cycles, then 1. LW at 0x3FC returns 0x00000000. A store issued during CLEAR does not land.
- Byte/half stores:
  - Stimulus: SW 0x11223344 @0x10; SB 0xAB @0x11; SH 0xBEEF @0x12.
  - Response: LW @0x10 returns 0xBEEFAB44.
- Load extension:
  - Stimulus: SW 0x80FF7F01 @0x20.
  - Response: LB @0x22 returns 0xFFFFFFFF; LBU @0x22 returns 0x000000FF; LH @0x22 returns 0xFFFF80FF; LHU @0x20 returns 0x00007F01.
- Faults and sticky capture:
  - Stimulus: SW @0x06, then SH @0x401, then LB with funct3=011.
  - Response: o_misaligned=1 each cycle. No memory change. o_faultAddress=0x00000006 is held. o_faultSticky=1 until reset.
- Reset mid-sweep:
  - Stimulus: assert i_rst_n=0 at cycle 100 of the sweep.
  - Response: clearIdx returns to 0. o_ready rises 256 cycles after release.
- Read/write same cycle:
  - Stimulus: word @0x30=0xAAAAAAAA; SW 0x55555555 @0x30 with i_memReadEn=1.
  - Response: o_readData=0xAAAAAAAA that cycle, 0x55555555 the next cycle.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared types for the data memory: load/store width codes and the clear/ready FSM states.
package pa_riscv;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_width_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_e;

  function automatic logic is_legal_store(input logic [2:0] funct3);
    return (funct3 == MEM_B) || (funct3 == MEM_H) || (funct3 == MEM_W);
  endfunction

  function automatic logic is_legal_load(input logic [2:0] funct3);
    return (funct3 == MEM_B) || (funct3 == MEM_H) || (funct3 == MEM_W) ||
           (funct3 == MEM_BU) || (funct3 == MEM_HU);
  endfunction

endpackage

// File: rtl/data_memory_load_extend.sv
// Selects the addressed byte/half of a loaded word and sign- or zero-extends it.
module load_extend
  import pa_riscv::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [1:0]        i_byte_sel,
  input  logic [2:0]        i_funct3,
  output logic [WORD_W-1:0] o_data
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = 8'(i_word >> {i_byte_sel, 3'b000});
    half_c = 16'(i_word >> {i_byte_sel[1], 4'b0000});
    o_data = '0;
    case (i_funct3)
      MEM_B:   o_data = {{24{byte_c[7]}}, byte_c};
      MEM_H:   o_data = {{16{half_c[15]}}, half_c};
      MEM_W:   o_data = i_word;
      MEM_BU:  o_data = {24'h0, byte_c};
      MEM_HU:  o_data = {16'h0, half_c};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable data memory with post-reset clearing sweep, access checking
// and a sticky capture of the first faulting address.
module data_memory
  import pa_riscv::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_memWriteEn,
  input  logic              i_memReadEn,
  input  logic [2:0]        i_funct3,
  input  logic [WORD_W-1:0] i_address,
  input  logic [WORD_W-1:0] i_writeData,
  output logic [WORD_W-1:0] o_readData,
  output logic              o_ready,
  output logic              o_misaligned,
  output logic              o_faultSticky,
  output logic [WORD_W-1:0] o_faultAddress
);

  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);

  mem_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   clear_idx_q, clear_idx_d;
  logic                ready_q, ready_d;
  logic                fault_sticky_q, fault_sticky_d;
  logic [WORD_W-1:0]   fault_address_q, fault_address_d;
  logic [WORD_W-1:0]   mem_q [DEPTH_WORDS];

  logic                illegal_c, unaligned_c, out_of_range_c, misaligned_c;
  logic [ADDR_W-1:0]   word_idx_c;
  logic                mem_we_c;
  logic [ADDR_W-1:0]   mem_idx_c;
  logic [WORD_W-1:0]   mem_wdata_c;
  logic [BYTES_PER_WORD-1:0] mem_be_c;
  logic [WORD_W-1:0]   rd_word_c, load_ext_c;

  assign word_idx_c = i_address[ADDR_W+1:2];

  // Access checking: illegal width code, natural alignment, and address range.
  always_comb begin
    illegal_c   = (i_memWriteEn & ~is_legal_store(i_funct3)) |
                  (i_memReadEn  & ~is_legal_load(i_funct3));
    unaligned_c = 1'b0;
    case (i_funct3)
      MEM_H, MEM_HU: unaligned_c = i_address[0];
      MEM_W:         unaligned_c = |i_address[1:0];
      default:       unaligned_c = 1'b0;
    endcase
    out_of_range_c = |i_address[WORD_W-1:ADDR_W+2];
    misaligned_c   = (state_q == READY) & (i_memReadEn | i_memWriteEn) &
                     (illegal_c | unaligned_c | out_of_range_c);
  end

  always_comb begin
    state_d         = state_q;
    clear_idx_d     = clear_idx_q;
    ready_d         = ready_q;
    fault_sticky_d  = fault_sticky_q;
    fault_address_d = fault_address_q;
    mem_we_c        = 1'b0;
    mem_idx_c       = word_idx_c;
    mem_wdata_c     = i_writeData;
    mem_be_c        = '0;
    case (state_q)
      CLEAR: begin
        mem_we_c    = 1'b1;
        mem_idx_c   = clear_idx_q;
        mem_wdata_c = '0;
        mem_be_c    = '1;
        clear_idx_d = clear_idx_q + ADDR_W'(1);
        if (clear_idx_q == ADDR_W'(DEPTH_WORDS - 1)) begin
          state_d = READY;
          ready_d = 1'b1;
        end
      end
      READY: begin
        if (misaligned_c && !fault_sticky_q) begin
          fault_sticky_d  = 1'b1;
          fault_address_d = i_address;
        end
        if (i_memWriteEn && !misaligned_c) begin
          mem_we_c = 1'b1;
          case (i_funct3)
            MEM_B: begin
              mem_be_c    = 4'(4'b0001 << i_address[1:0]);
              mem_wdata_c = {4{i_writeData[7:0]}};
            end
            MEM_H: begin
              mem_be_c    = i_address[1] ? 4'b1100 : 4'b0011;
              mem_wdata_c = {2{i_writeData[15:0]}};
            end
            default: mem_be_c = '1;
          endcase
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q         <= CLEAR;
      clear_idx_q     <= '0;
      ready_q         <= 1'b0;
      fault_sticky_q  <= 1'b0;
      fault_address_q <= '0;
    end else begin
      state_q         <= state_d;
      clear_idx_q     <= clear_idx_d;
      ready_q         <= ready_d;
      fault_sticky_q  <= fault_sticky_d;
      fault_address_q <= fault_address_d;
    end
  end

  // Storage has no reset; the sweep zeroes it once reset is released.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && mem_we_c) begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
        if (mem_be_c[b]) mem_q[mem_idx_c][8*b +: 8] <= mem_wdata_c[8*b +: 8];
      end
    end
  end

  assign rd_word_c = mem_q[word_idx_c];

  load_extend u_load_extend (
    .i_word     (rd_word_c),
    .i_byte_sel (i_address[1:0]),
    .i_funct3   (i_funct3),
    .o_data     (load_ext_c)
  );

  assign o_readData     = (state_q == READY && i_memReadEn && !misaligned_c) ? load_ext_c : '0;
  assign o_misaligned   = misaligned_c;
  assign o_ready        = ready_q;
  assign o_faultSticky  = fault_sticky_q;
  assign o_faultAddress = fault_address_q;

endmodule
